mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
// - Writeback stage directly downstream of the data-memory stage. Captures the load word,
//   load byte and ALU result, selects the writeback value, and queues results for the
//   register-file write port.
// - Buffers up to DEPTH results in a circular FIFO so a busy write port (wb_ready low)
//   back-pressures the memory stage without losing data.
// - Provides a forwarding lookup over queued, not-yet-written results.
// PARAMETERS
// - DATA_W  32  datapath width (Do, ALU result, wb_data)
// - BYTE_W   8  load-byte width (Dob)
// - RG_W     4  destination register index width
// - DEPTH    2  FIFO entries; power of two, >=2
// PORTS
// - clk          in   1       clock, rising edge
// - rst_n        in   1       asynchronous reset, active low
// - in_valid     in   1       upstream result valid this cycle
// - in_ready     out  1       stage can accept (registered, = count<DEPTH)
// - Do           in   DATA_W  loaded word from data memory
// - Dob          in   BYTE_W  loaded byte from data memory
// - ALU_Result   in   DATA_W  ALU result passed through the memory stage
// - Rg           in   RG_W    destination register
// - wb_sel       in   2       0=ALU, 1=word load, 2=byte load (zero-ext), 3=no write
// - flush        in   1       discard all queued entries
// - wb_valid     out  1       head entry present (count>0)
// - wb_ready     in   1       register file accepts head this cycle
// - wb_rg        out  RG_W    head destination register
// - wb_data      out  DATA_W  head writeback value
// - fwd_rg_q     in   RG_W    forwarding query register
// - fwd_hit      out  1       some queued entry targets fwd_rg_q
// - fwd_data     out  DATA_W  value of youngest matching entry (0 when no hit)
// - count        out  log2(DEPTH)+1  queued entries
// BEHAVIOUR
// - Reset (rst_n=0, async): rd/wr pointers=0, count=0, in_ready=1, wb_valid=0,
//   wb_rg=0, wb_data=0, fwd_hit=0, fwd_data=0. FIFO contents are don't-care.
// - Push: in_valid & in_ready & wb_sel!=3. The value is selected on entry:
//   sel0 gives ALU_Result, sel1 gives Do, sel2 gives {zeros,Dob}.
// - wb_sel=3 with in_valid & in_ready: handshake completes, nothing is stored.
// - Pop: wb_valid & wb_ready. The head advances at the clock edge.
// - Latency: data pushed at edge N is on wb_* from edge N onward when the FIFO was empty.
//   There is no combinational in->wb bypass.
// - in_ready depends only on registered count. When the FIFO is full, in_ready=0 even if
//   a pop occurs in the same cycle; there is no ready-through path.
// - Simultaneous push and pop (count not full): count unchanged; both pointers advance.
// - Pointers wrap modulo DEPTH. count saturates at DEPTH by construction.
// - flush (synchronous): count=0 and pointers=0 at the next edge. It overrides any push
//   or pop in that cycle. wb_valid=0 the following cycle.
// - Forwarding is combinational over valid entries only, including the head being popped
//   this cycle. The youngest entry wins on multiple matches.
// - wb_rg/wb_data read the head entry combinationally. They are 0 when count=0.
// - rst_n asserted mid-transfer empties the FIFO immediately. Any partial handshake is
//   dropped.
// TESTING
// - Reset: rst_n=0 -> in_ready=1, wb_valid=0, count=0, fwd_hit=0. Release rst_n -> values held.
// - Select: push {ALU=0x11223344, sel0, Rg=3}, {Do=0xDEADBEEF, sel1, Rg=4},
//   {Dob=0xA5, sel2, Rg=5} with wb_ready=1 ->
//   wb_data 0x11223344, 0xDEADBEEF, 0x000000A5 in order.
// - Backpressure: wb_ready=0, push 3 entries -> third stalls with in_ready=0, count=2.
//   Raise wb_ready -> all 3 drain in order, none lost.
// - Full + pop same cycle: count=2, wb_ready=1, in_valid=1 -> in_ready=0 that cycle,
//   count=1 next cycle.
// - Forwarding: queue Rg=7 with 0x10, then Rg=7 with 0x20. Query 7 -> hit, 0x20.
//   Query 2 -> fwd_hit=0, fwd_data=0.
// - Flush/no-write: sel=3 push -> count unchanged. flush with push+pop active -> count=0
//   next cycle. Mid-stream rst_n pulse -> wb_valid=0 asynchronously.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-to-writeback stage: selects the writeback value, queues results in a small
// circular FIFO for the register-file write port, and forwards queued values.
module mem_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BYTE_W = 8,
  parameter int unsigned RG_W   = 4,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          Do,
  input  logic [BYTE_W-1:0]          Dob,
  input  logic [DATA_W-1:0]          ALU_Result,
  input  logic [RG_W-1:0]            Rg,
  input  logic [1:0]                 wb_sel,
  input  logic                       flush,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [RG_W-1:0]            wb_rg,
  output logic [DATA_W-1:0]          wb_data,
  input  logic [RG_W-1:0]            fwd_rg_q,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'd0,
    SEL_WORD = 2'd1,
    SEL_BYTE = 2'd2,
    SEL_NONE = 2'd3
  } wb_sel_e;

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [RG_W-1:0]   r_rg   [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  wb_sel_e           w_sel;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_entry_data;

  assign w_sel    = wb_sel_e'(wb_sel);
  assign in_ready = (r_count != CNT_W'(DEPTH));
  assign wb_valid = (r_count != '0);
  assign w_push   = in_valid & in_ready & (w_sel != SEL_NONE);
  assign w_pop    = wb_valid & wb_ready;
  assign count    = r_count;

  always_comb begin
    w_entry_data = ALU_Result;
    case (w_sel)
      SEL_WORD: w_entry_data = Do;
      SEL_BYTE: w_entry_data = {{(DATA_W-BYTE_W){1'b0}}, Dob};
      default:  w_entry_data = ALU_Result;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is left unreset; only count/pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_data[r_wr_ptr] <= w_entry_data;
      r_rg[r_wr_ptr]   <= Rg;
    end
  end

  assign wb_rg   = wb_valid ? r_rg[r_rd_ptr]   : '0;
  assign wb_data = wb_valid ? r_data[r_rd_ptr] : '0;

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) && (r_rg[r_rd_ptr + PTR_W'(i)] == fwd_rg_q)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_data[r_rd_ptr + PTR_W'(i)];
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed, table-driven bench for mem_wb_stage with hand-written reset/flush sequences.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Do;
  logic [7:0]  Dob;
  logic [31:0] ALU_Result;
  logic [3:0]  Rg;
  logic [1:0]  wb_sel;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_rg;
  logic [31:0] wb_data;
  logic [3:0]  fwd_rg_q;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [1:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  mem_wb_stage #(.DATA_W(32), .BYTE_W(8), .RG_W(4), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Do(Do), .Dob(Dob), .ALU_Result(ALU_Result), .Rg(Rg), .wb_sel(wb_sel),
    .flush(flush), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rg(wb_rg),
    .wb_data(wb_data), .fwd_rg_q(fwd_rg_q), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic [3:0]  rg;
    logic [31:0] alu;
    logic [31:0] dw;
    logic [7:0]  db;
    logic        fl;
    logic        wr;
    logic [3:0]  q;
    logic        e_rdy;
    logic        e_vld;
    logic [3:0]  e_rg;
    logic [31:0] e_data;
    logic        e_hit;
    logic [31:0] e_fd;
    logic [1:0]  e_cnt;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(logic iv, logic [1:0] sel, logic [3:0] rg, logic [31:0] alu,
                              logic [31:0] dw, logic [7:0] db, logic fl, logic wr,
                              logic [3:0] q, logic e_rdy, logic e_vld, logic [3:0] e_rg,
                              logic [31:0] e_data, logic e_hit, logic [31:0] e_fd,
                              logic [1:0] e_cnt);
    vec_t v;
    v.iv = iv; v.sel = sel; v.rg = rg; v.alu = alu; v.dw = dw; v.db = db;
    v.fl = fl; v.wr = wr; v.q = q; v.e_rdy = e_rdy; v.e_vld = e_vld;
    v.e_rg = e_rg; v.e_data = e_data; v.e_hit = e_hit; v.e_fd = e_fd; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; wb_sel = 2'd0; Rg = '0; ALU_Result = '0; Do = '0; Dob = '0;
    flush = 1'b0;
  endtask

  task automatic push(input logic [3:0] rg, input logic [31:0] alu);
    in_valid = 1'b1; wb_sel = 2'd0; Rg = rg; ALU_Result = alu; flush = 1'b0;
  endtask

  initial begin
    //            iv sel rg  alu           dw            db     fl wr q    rdy vld rg  data          hit fd            cnt
    tbl[0]  = mk(0, 0, 0, 32'h0,        32'h0,        8'h00, 0, 0, 0,   1, 0, 0, 32'h0,        0, 32'h0,        0);
    tbl[1]  = mk(1, 0, 3, 32'h11223344, 32'h55,       8'h66, 0, 1, 3,   1, 0, 0, 32'h0,        0, 32'h0,        0);
    tbl[2]  = mk(1, 1, 4, 32'h77,       32'hDEADBEEF, 8'h66, 0, 1, 3,   1, 1, 3, 32'h11223344, 1, 32'h11223344, 1);
    tbl[3]  = mk(1, 2, 5, 32'h99,       32'hFFFFFFFF, 8'hA5, 0, 1, 5,   1, 1, 4, 32'hDEADBEEF, 0, 32'h0,        1);
    tbl[4]  = mk(0, 0, 0, 32'h0,        32'h0,        8'h00, 0, 1, 5,   1, 1, 5, 32'h000000A5, 1, 32'h000000A5, 1);
    tbl[5]  = mk(0, 0, 0, 32'h0,        32'h0,        8'h00, 0, 0, 5,   1, 0, 0, 32'h0,        0, 32'h0,        0);
    tbl[6]  = mk(1, 0, 1, 32'h101,      32'h0,        8'h00, 0, 0, 1,   1, 0, 0, 32'h0,        0, 32'h0,        0);
    tbl[7]  = mk(1, 0, 2, 32'h202,      32'h0,        8'h00, 0, 0, 1,   1, 1, 1, 32'h101,      1, 32'h101,      1);
    tbl[8]  = mk(1, 0, 3, 32'h303,      32'h0,        8'h00, 0, 0, 3,   0, 1, 1, 32'h101,      0, 32'h0,        2);
    tbl[9]  = mk(1, 0, 3, 32'h303,      32'h0,        8'h00, 0, 0, 2,   0, 1, 1, 32'h101,      1, 32'h202,      2);
    tbl[10] = mk(1, 0, 3, 32'h303,      32'h0,        8'h00, 0, 1, 1,   0, 1, 1, 32'h101,      1, 32'h101,      2);
    tbl[11] = mk(1, 0, 3, 32'h303,      32'h0,        8'h00, 0, 1, 2,   1, 1, 2, 32'h202,      1, 32'h202,      1);
    tbl[12] = mk(0, 0, 0, 32'h0,        32'h0,        8'h00, 0, 1, 3,   1, 1, 3, 32'h303,      1, 32'h303,      1);
    tbl[13] = mk(0, 0, 0, 32'h0,        32'h0,        8'h00, 0, 0, 3,   1, 0, 0, 32'h0,        0, 32'h0,        0);
    tbl[14] = mk(1, 0, 7, 32'h10,       32'h0,        8'h00, 0, 0, 7,   1, 0, 0, 32'h0,        0, 32'h0,        0);
    tbl[15] = mk(1, 1, 7, 32'h0,        32'h20,       8'h00, 0, 0, 7,   1, 1, 7, 32'h10,       1, 32'h10,       1);
    tbl[16] = mk(0, 0, 0, 32'h0,        32'h0,        8'h00, 0, 0, 7,   0, 1, 7, 32'h10,       1, 32'h20,       2);
    tbl[17] = mk(0, 0, 0, 32'h0,        32'h0,        8'h00, 0, 0, 2,   0, 1, 7, 32'h10,       0, 32'h0,        2);
    tbl[18] = mk(0, 0, 0, 32'h0,        32'h0,        8'h00, 0, 1, 7,   0, 1, 7, 32'h10,       1, 32'h20,       2);
    tbl[19] = mk(1, 3, 9, 32'h99,       32'h99,       8'h99, 0, 0, 9,   1, 1, 7, 32'h20,       0, 32'h0,        1);
    tbl[20] = mk(0, 0, 0, 32'h0,        32'h0,        8'h00, 0, 0, 9,   1, 1, 7, 32'h20,       0, 32'h0,        1);
    tbl[21] = mk(1, 0, 6, 32'h66,       32'h0,        8'h00, 1, 1, 7,   1, 1, 7, 32'h20,       1, 32'h20,       1);
    tbl[22] = mk(0, 0, 0, 32'h0,        32'h0,        8'h00, 0, 0, 7,   1, 0, 0, 32'h0,        0, 32'h0,        0);

    rst_n = 1'b0; wb_ready = 1'b0; fwd_rg_q = '0;
    drive_idle();
    #3;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_count",    {30'b0, count},    32'd0);
    chk("rst_fwd_hit",  {31'b0, fwd_hit},  32'd0);
    chk("rst_wb_data",  wb_data,           32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rel_count",    {30'b0, count},    32'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = tbl[i].iv; wb_sel = tbl[i].sel; Rg = tbl[i].rg;
      ALU_Result = tbl[i].alu; Do = tbl[i].dw; Dob = tbl[i].db;
      flush = tbl[i].fl; wb_ready = tbl[i].wr; fwd_rg_q = tbl[i].q;
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].e_rdy});
      chk($sformatf("v%0d_wb_valid", i), {31'b0, wb_valid}, {31'b0, tbl[i].e_vld});
      chk($sformatf("v%0d_wb_rg", i),    {28'b0, wb_rg},    {28'b0, tbl[i].e_rg});
      chk($sformatf("v%0d_wb_data", i),  wb_data,           tbl[i].e_data);
      chk($sformatf("v%0d_fwd_hit", i),  {31'b0, fwd_hit},  {31'b0, tbl[i].e_hit});
      chk($sformatf("v%0d_fwd_data", i), fwd_data,          tbl[i].e_fd);
      chk($sformatf("v%0d_count", i),    {30'b0, count},    {30'b0, tbl[i].e_cnt});
    end

    // Fill, then assert reset away from any clock edge.
    @(negedge clk); wb_ready = 1'b0; fwd_rg_q = 4'd1; push(4'd1, 32'hAA);
    @(negedge clk); push(4'd2, 32'hBB);
    @(negedge clk); drive_idle(); #1;
    chk("pre_rst_count", {30'b0, count}, 32'd2);
    chk("pre_rst_hit",   {31'b0, fwd_hit}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("async_rst_count",    {30'b0, count},    32'd0);
    chk("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("async_rst_wb_data",  wb_data,           32'd0);
    chk("async_rst_fwd_hit",  {31'b0, fwd_hit},  32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("post_rst_count", {30'b0, count}, 32'd0);
    @(negedge clk); push(4'd12, 32'hCC);
    @(negedge clk); drive_idle(); #1;
    chk("post_rst_push_count", {30'b0, count}, 32'd1);
    chk("post_rst_push_rg",    {28'b0, wb_rg}, 32'd12);
    chk("post_rst_push_data",  wb_data,        32'hCC);

    // Flush while full with both push and pop requested.
    @(negedge clk); push(4'd13, 32'hDD);
    @(negedge clk); drive_idle(); #1;
    chk("pre_flush_count", {30'b0, count}, 32'd2);
    @(negedge clk); push(4'd14, 32'hEE); flush = 1'b1; wb_ready = 1'b1;
    @(negedge clk); drive_idle(); wb_ready = 1'b0; #1;
    chk("flush_count",    {30'b0, count},    32'd0);
    chk("flush_wb_valid", {31'b0, wb_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
